// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR tile sequencer slice.
// Holds the FSM encoding, tile geometry and decoded-element field layout.
package csr_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_LAUNCH,
        S_RUN,
        S_DRAIN,
        S_NEXT,
        S_FLUSH
    } state_t;

    localparam int TILE_DIM  = 16;
    localparam int PTR_W     = 8;
    localparam int PTR_VEC_W = TILE_DIM * PTR_W;
    localparam int ELEM_W    = 16;
    localparam int ROW_LSB   = 12;
    localparam int COL_LSB   = 8;
    localparam int VAL_LSB   = 0;

    function automatic logic [ELEM_W-1:0] elem_pack(
        input logic [3:0] row,
        input logic [3:0] col,
        input logic [7:0] val
    );
        logic [ELEM_W-1:0] e;
        e = '0;
        e[ROW_LSB +: 4] = row;
        e[COL_LSB +: 4] = col;
        e[VAL_LSB +: 8] = val;
        return e;
    endfunction

endpackage

// File: rtl/csr_out_fifo.sv
// Small output FIFO toward the PE array; a push into a full FIFO
// succeeds only if a pop happens in the same cycle, else it is dropped.
module csr_out_fifo
    import csr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ELEM_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         do_pop;
    logic         do_push;

    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        drop    = push && !do_push;
        wr_d    = wr_q + {{AW{1'b0}}, do_push};
        rd_d    = rd_q + {{AW{1'b0}}, do_pop};
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = din;
        end
    end

    assign dout = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/csr_tile_sequencer.sv
// Walks a job of CSR tiles through the decoder: fetch descriptor, launch,
// serve value reads, collect decoded elements into the output FIFO.
module csr_tile_sequencer
    import csr_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DESC_AW    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           tile_count,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [DESC_AW-1:0]   desc_addr,
    input  logic [PTR_VEC_W-1:0] desc_ptr,
    input  logic [7:0]           desc_nz,
    input  logic [ADDR_W-1:0]    desc_base,
    output logic [ADDR_W-1:0]    val_addr,
    input  logic [7:0]           val_rdata,
    output logic                 dec_rst_n,
    output logic                 dec_enable,
    output logic [135:0]         dec_index_pointer,
    output logic [7:0]           dec_nz_count,
    output logic [3:0]           dec_row,
    output logic [7:0]           dec_data,
    input  logic                 dec_read,
    input  logic                 dec_write,
    input  logic [15:0]          dec_indexed_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_data
);

    state_t                 state_q, state_d;
    logic [7:0]             tile_idx_q, tile_idx_d;
    logic [7:0]             tile_cnt_q, tile_cnt_d;
    logic [PTR_VEC_W-1:0]   ptr_q, ptr_d;
    logic [7:0]             nz_q, nz_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [7:0]             elem_cnt_q, elem_cnt_d;
    logic [7:0]             rd_cnt_q, rd_cnt_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;
    logic                   fifo_push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_drop;

    always_comb begin
        state_d    = state_q;
        tile_idx_d = tile_idx_q;
        tile_cnt_d = tile_cnt_q;
        ptr_d      = ptr_q;
        nz_d       = nz_q;
        base_d     = base_q;
        elem_cnt_d = elem_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        dec_enable = 1'b0;
        fifo_push  = dec_write && (state_q == S_RUN);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (tile_count == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = S_FETCH;
                        tile_idx_d = 8'd0;
                        tile_cnt_d = tile_count;
                    end
                end
            end
            S_FETCH: state_d = S_CHECK;
            S_CHECK: begin
                ptr_d      = desc_ptr;
                nz_d       = desc_nz;
                base_d     = desc_base;
                elem_cnt_d = 8'd0;
                rd_cnt_d   = 8'd0;
                // An empty tile must never reach the decoder: it would not terminate.
                state_d    = (desc_nz == 8'd0) ? S_NEXT : S_LAUNCH;
            end
            S_LAUNCH: begin
                dec_enable = 1'b1;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (dec_read) begin
                    rd_cnt_d = rd_cnt_q + 8'd1;
                end
                if (dec_write) begin
                    elem_cnt_d = elem_cnt_q + 8'd1;
                    if (elem_cnt_q + 8'd1 == nz_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: state_d = S_NEXT;
            S_NEXT: begin
                tile_idx_d = tile_idx_q + 8'd1;
                state_d    = (tile_idx_q + 8'd1 == tile_cnt_q) ? S_FLUSH : S_FETCH;
            end
            S_FLUSH: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fifo_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tile_idx_q <= '0;
            tile_cnt_q <= '0;
            ptr_q      <= '0;
            nz_q       <= '0;
            base_q     <= '0;
            elem_cnt_q <= '0;
            rd_cnt_q   <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tile_idx_q <= tile_idx_d;
            tile_cnt_q <= tile_cnt_d;
            ptr_q      <= ptr_d;
            nz_q       <= nz_d;
            base_q     <= base_d;
            elem_cnt_q <= elem_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    csr_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (dec_indexed_data),
        .pop   (out_ready),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign busy              = (state_q != S_IDLE);
    assign done              = done_q;
    assign overflow          = ovf_q;
    assign desc_addr         = DESC_AW'(tile_idx_q);
    assign val_addr          = base_q + ADDR_W'(rd_cnt_q);
    assign dec_rst_n         = ~rst;
    assign dec_index_pointer = {8'h00, ptr_q};
    assign dec_nz_count      = nz_q;
    assign dec_row           = tile_idx_q[3:0];
    assign dec_data          = val_rdata;
    assign out_valid         = !fifo_empty && !fifo_full ? 1'b1 : !fifo_empty;

endmodule

// File: tb/tb_csr_tile_sequencer.sv
// Bench for csr_tile_sequencer: memories and a decoder stand-in around the
// DUT, with a queue-level model of the element stream and FIFO occupancy.
module tb_csr_tile_sequencer;

    localparam int ADDR_W  = 12;
    localparam int DESC_AW = 8;
    localparam int DEPTH   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [7:0]          tile_count;
    logic                busy, done, overflow;
    logic [DESC_AW-1:0]  desc_addr;
    logic [127:0]        desc_ptr;
    logic [7:0]          desc_nz;
    logic [ADDR_W-1:0]   desc_base;
    logic [ADDR_W-1:0]   val_addr;
    logic [7:0]          val_rdata;
    logic                dec_rst_n, dec_enable;
    logic [135:0]        dec_index_pointer;
    logic [7:0]          dec_nz_count;
    logic [3:0]          dec_row;
    logic [7:0]          dec_data;
    logic                dec_read = 1'b0;
    logic                dec_write = 1'b0;
    logic [15:0]         dec_indexed_data = '0;
    logic                out_valid;
    logic                out_ready;
    logic [15:0]         out_data;

    csr_tile_sequencer #(
        .ADDR_W     (ADDR_W),
        .DESC_AW    (DESC_AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .tile_count        (tile_count),
        .busy              (busy),
        .done              (done),
        .overflow          (overflow),
        .desc_addr         (desc_addr),
        .desc_ptr          (desc_ptr),
        .desc_nz           (desc_nz),
        .desc_base         (desc_base),
        .val_addr          (val_addr),
        .val_rdata         (val_rdata),
        .dec_rst_n         (dec_rst_n),
        .dec_enable        (dec_enable),
        .dec_index_pointer (dec_index_pointer),
        .dec_nz_count      (dec_nz_count),
        .dec_row           (dec_row),
        .dec_data          (dec_data),
        .dec_read          (dec_read),
        .dec_write         (dec_write),
        .dec_indexed_data  (dec_indexed_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [127:0] dptr  [256];
    logic [7:0]   dnz   [256];
    logic [11:0]  dbase [256];
    logic [7:0]   vmem  [4096];

    logic [31:0] exp_elem[$], exp_addr[$], exp_row[$];
    logic [15:0] mq[$];
    logic [31:0] got_out[$], got_addr[$], got_row[$];
    logic        ov_m = 1'b0;
    int          exp_en, en_cnt, done_cnt, wr_cnt;
    logic        busy_seen;
    int          rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Row of element k: number of rows whose end pointer is already <= k.
    function automatic logic [3:0] row_of(input logic [127:0] p, input int k);
        int r = 0;
        for (int i = 0; i < 16; i++) begin
            if (int'(p[127-8*i -: 8]) <= k) r++;
        end
        if (r > 15) r = 15;
        return 4'(r);
    endfunction

    // Synchronous descriptor and value memories.
    always @(posedge clk) begin
        desc_ptr  <= dptr[desc_addr];
        desc_nz   <= dnz[desc_addr];
        desc_base <= dbase[desc_addr];
        val_rdata <= vmem[val_addr];
    end

    // Decoder stand-in: read, wait a cycle, sample value, emit element.
    int           dm_k = 0;
    int           dm_ph = 0;
    logic         dm_on = 1'b0;
    logic [7:0]   dm_nz = '0;
    logic [127:0] dm_ptr = '0;

    always @(posedge clk) begin
        if (!dec_rst_n) begin
            dm_on     <= 1'b0;
            dm_ph     <= 0;
            dm_k      <= 0;
            dec_read  <= 1'b0;
            dec_write <= 1'b0;
        end else begin
            dec_read  <= 1'b0;
            dec_write <= 1'b0;
            if (dec_enable) begin
                dm_on  <= 1'b1;
                dm_k   <= 0;
                dm_ph  <= 0;
                dm_nz  <= dec_nz_count;
                dm_ptr <= dec_index_pointer[127:0];
            end else if (dm_on) begin
                case (dm_ph)
                    0: if ($urandom_range(3) != 0) begin
                        dec_read <= 1'b1;
                        dm_ph    <= 1;
                    end
                    1: dm_ph <= 2;
                    default: begin
                        dec_write        <= 1'b1;
                        dec_indexed_data <= {row_of(dm_ptr, dm_k), 4'(dm_k), dec_data};
                        dm_ph            <= 0;
                        dm_k             <= dm_k + 1;
                        if (dm_k + 1 == int'(dm_nz)) dm_on <= 1'b0;
                    end
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = ($urandom_range(3) != 0);
        endcase
    end

    logic [31:0] e;

    always @(negedge clk) begin
        if (rst) begin
            chk("dec_rst_n_low", dec_rst_n, 0);
            mq.delete();
            ov_m = 1'b0;
            exp_elem.delete();
            exp_addr.delete();
            exp_row.delete();
        end else begin
            chk("dec_rst_n_high", dec_rst_n, 1);
            chk("out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) chk("out_data", out_data, mq[0]);
            chk("overflow", overflow, ov_m);
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 0);
            end
            if (busy) busy_seen = 1'b1;
            if (dec_enable) begin
                en_cnt++;
                got_row.push_back(dec_row);
                chk("ptr_hi", dec_index_pointer[135:128], 0);
                e = (exp_row.size() != 0) ? exp_row[0] : 32'hFFFF_FFFF;
                if (exp_row.size() != 0) void'(exp_row.pop_front());
                chk("dec_row", dec_row, e);
            end
            if (dec_read) begin
                got_addr.push_back(val_addr);
                e = (exp_addr.size() != 0) ? exp_addr[0] : 32'hFFFF_FFFF;
                if (exp_addr.size() != 0) void'(exp_addr.pop_front());
                chk("val_addr", val_addr, e);
            end
            if (dec_write) begin
                wr_cnt++;
                e = (exp_elem.size() != 0) ? exp_elem[0] : 32'hFFFF_FFFF;
                if (exp_elem.size() != 0) void'(exp_elem.pop_front());
                chk("elem", dec_indexed_data, e);
            end
            if (out_valid && out_ready) got_out.push_back(out_data);
            if (start) ov_m = 1'b0;
            if (out_ready && mq.size() != 0) void'(mq.pop_front());
            if (dec_write) begin
                if (mq.size() < DEPTH) mq.push_back(dec_indexed_data);
                else ov_m = 1'b1;
            end
        end
    end

    task automatic set_tile(input int i, input int nz, input logic [11:0] base);
        int v = 0;
        logic [127:0] p;
        for (int r = 0; r < 15; r++) begin
            v += $urandom_range(0, (nz - v + 3) / 4);
            if (v > nz) v = nz;
            p[127-8*r -: 8] = 8'(v);
        end
        p[7:0]   = 8'(nz);
        dptr[i]  = p;
        dnz[i]   = 8'(nz);
        dbase[i] = base;
    endtask

    task automatic start_job(input int tc);
        logic [11:0] a;
        exp_elem.delete();
        exp_addr.delete();
        exp_row.delete();
        got_out.delete();
        got_addr.delete();
        got_row.delete();
        exp_en = 0;
        en_cnt = 0;
        done_cnt = 0;
        wr_cnt = 0;
        busy_seen = 1'b0;
        for (int i = 0; i < tc; i++) begin
            if (dnz[i] != 0) begin
                exp_en++;
                exp_row.push_back(32'(i[3:0]));
                for (int k = 0; k < int'(dnz[i]); k++) begin
                    a = dbase[i] + 12'(k);
                    exp_addr.push_back(32'(a));
                    exp_elem.push_back({16'h0, row_of(dptr[i], k), 4'(k), vmem[a]});
                end
            end
        end
        @(posedge clk); #1;
        start = 1'b1;
        tile_count = 8'(tc);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", done === 1'b1, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("done_cnt", done_cnt, 1);
        chk("en_cnt", en_cnt, exp_en);
        chk("elems_left", exp_elem.size(), 0);
        chk("addrs_left", exp_addr.size(), 0);
        chk("busy_after", busy, 0);
    endtask

    task automatic wait_wr(input int n, input int limit);
        int c = 0;
        while (wr_cnt < n && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk("wr_timeout", wr_cnt >= n, 1);
    endtask

    int tc;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        tile_count = 8'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 4096; i++) vmem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) set_tile(i, 0, 12'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dec_enable", dec_enable, 0);
        chk("rst_val_addr", val_addr, 0);
        chk("rst_nz", dec_nz_count, 0);
        chk("rst_ptr", dec_index_pointer[31:0], 0);

        // Single tile, nz=3, known pointers and values.
        dptr[0]  = {8'd1, 8'd2, {14{8'd3}}};
        dnz[0]   = 8'd3;
        dbase[0] = 12'h010;
        vmem[12'h010] = 8'h11;
        vmem[12'h011] = 8'h22;
        vmem[12'h012] = 8'h33;
        start_job(1);
        @(negedge clk); chk("en_fetch", dec_enable, 0);
        @(negedge clk); chk("en_check", dec_enable, 0);
        @(negedge clk); chk("en_launch", dec_enable, 1);
        wait_done(500);
        chk("t1_n_out", got_out.size(), 3);
        if (got_out.size() == 3) begin
            chk("t1_out0", got_out[0], 32'h0011);
            chk("t1_out1", got_out[1], 32'h1122);
            chk("t1_out2", got_out[2], 32'h2233);
        end
        chk("t1_n_addr", got_addr.size(), 3);
        if (got_addr.size() == 3) begin
            chk("t1_addr0", got_addr[0], 32'h010);
            chk("t1_addr2", got_addr[2], 32'h012);
        end

        // Three tiles, middle one empty.
        set_tile(0, 2, 12'h100);
        set_tile(1, 0, 12'h200);
        set_tile(2, 3, 12'h300);
        start_job(3);
        wait_done(500);
        chk("t2_en_pulses", en_cnt, 2);
        chk("t2_n_rows", got_row.size(), 2);
        if (got_row.size() == 2) begin
            chk("t2_row0", got_row[0], 0);
            chk("t2_row1", got_row[1], 2);
        end
        chk("t2_n_out", got_out.size(), 5);

        // Empty job.
        start_job(0);
        chk("t3_done_next", done, 1);
        chk("t3_busy", busy, 0);
        wait_done(20);
        chk("t3_busy_seen", busy_seen, 0);
        chk("t3_en", en_cnt, 0);

        // Downstream stalled for a whole 8-element job.
        rdy_mode = 1;
        set_tile(0, 5, 12'h400);
        set_tile(1, 3, 12'h500);
        start_job(2);
        wait_wr(8, 500);
        repeat (4) @(negedge clk);
        chk("t4_overflow", overflow, 1);
        chk("t4_done_held", done_cnt, 0);
        chk("t4_busy", busy, 1);
        chk("t4_valid", out_valid, 1);
        rdy_mode = 0;
        wait_done(200);
        chk("t4_kept", got_out.size(), 4);

        // Reset in the middle of a tile.
        rdy_mode = 1;
        set_tile(0, 5, 12'h600);
        start_job(1);
        wait_wr(2, 500);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_overflow", overflow, 0);
        chk("t5_enable", dec_enable, 0);
        rdy_mode = 0;
        set_tile(0, 4, 12'h700);
        set_tile(1, 2, 12'h710);
        start_job(2);
        wait_done(500);
        chk("t5_row0", (got_row.size() != 0) ? got_row[0] : 32'hFFFF_FFFF, 0);
        chk("t5_n_out", got_out.size(), 6);

        // Full tile wrapping the value address space.
        set_tile(0, 255, 12'hFF0);
        start_job(1);
        wait_done(20000);
        chk("t6_n_out", got_out.size(), 255);
        chk("t6_n_addr", got_addr.size(), 255);
        if (got_addr.size() == 255) begin
            chk("t6_addr_fff", got_addr[15], 32'hFFF);
            chk("t6_addr_000", got_addr[16], 32'h000);
        end

        // Random jobs with random downstream back-pressure.
        rdy_mode = 2;
        for (int j = 0; j < 6; j++) begin
            tc = $urandom_range(1, 5);
            for (int i = 0; i < tc; i++) begin
                set_tile(i, ($urandom_range(3) == 0) ? 0 : $urandom_range(1, 20), 12'($urandom));
            end
            start_job(tc);
            wait_done(5000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
